// File: rtl/tuart_tx_if.sv
// Transmit request bundle between the message queue and the Tiny-UART transmitter.
interface tuart_tx_if #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned CMD_WORDS = 4
);
    localparam int unsigned SEL_W  = $clog2(CMD_WORDS) + 1;
    localparam int unsigned DATA_W = WORD_BITS * CMD_WORDS;

    logic              stb;
    logic              rdy;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;

    modport master (output stb, output sel, output data, input rdy);
    modport slave  (input stb, input sel, input data, output rdy);
endinterface

// File: rtl/tuart_tx_queue.sv
// Message FIFO feeding the Tiny-UART transmitter; holds each request until accepted.
// Optional overflow flag enabled by defining LOGIP_TXQ_OVF_EN.
module tuart_tx_queue #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned CMD_WORDS = 4,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned SEL_W    = $clog2(CMD_WORDS) + 1,
    localparam int unsigned DATA_W   = WORD_BITS * CMD_WORDS,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              push_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
`ifdef LOGIP_TXQ_OVF_EN
    input  logic              clr_ovf_i,
    output logic              ovf_o,
`endif
    tuart_tx_if.master        tx
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state;
    logic              stb;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SEL_W-1:0]  mem_sel  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign do_push = push_i && !full && (sel_i != SEL_W'(0));
    // The transmitter dropping rdy while stb is held is the acceptance event.
    assign do_pop  = (state == ISSUE) && !tx.rdy;

    assign full_o    = full;
    assign empty_o   = empty;
    assign count_o   = count;
    assign tx.stb    = stb;
    assign tx.sel    = mem_sel[rd_ptr];
    assign tx.data   = mem_data[rd_ptr];

    // Entry storage, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_sel[wr_ptr]  <= sel_i;
            mem_data[wr_ptr] <= data_i;
        end
    end

    // Pointers, occupancy and transmit handshake FSM.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state  <= IDLE;
            stb    <= 1'b0;
            wr_ptr <= PTR_W'(0);
            rd_ptr <= PTR_W'(0);
            count  <= CNT_W'(0);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);

            case (state)
                IDLE: begin
                    if (!empty && tx.rdy) begin
                        state <= ISSUE;
                        stb   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!tx.rdy) begin
                        state <= WAIT_DONE;
                        stb   <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (tx.rdy) begin
                        if (!empty) begin
                            state <= ISSUE;
                            stb   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    stb   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOGIP_TXQ_OVF_EN
    logic ovf_set;
    assign ovf_set = push_i && full && (sel_i != SEL_W'(0));

    // Sticky overflow flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_in)        ovf_o <= 1'b0;
        else if (ovf_set)   ovf_o <= 1'b1;
        else if (clr_ovf_i) ovf_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_tuart_tx_queue.sv
// Scoreboard bench for tuart_tx_queue: directed pushes feed an expected queue, a transmitter model checks each accept.
module tb_tuart_tx_queue;

    localparam int unsigned WB = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned DP = 4;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
`ifdef LOGIP_TXQ_OVF_EN
    logic        clr_ovf;
    logic        ovf;
`endif

    always #5 clk = ~clk;

    tuart_tx_if #(.WORD_BITS(WB), .CMD_WORDS(CW)) tx_if ();

    tuart_tx_queue #(.WORD_BITS(WB), .CMD_WORDS(CW), .DEPTH(DP)) dut (
        .clk_i     (clk),
        .rst_in    (rst_n),
        .push_i    (push),
        .sel_i     (sel),
        .data_i    (data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
`ifdef LOGIP_TXQ_OVF_EN
        .clr_ovf_i (clr_ovf),
        .ovf_o     (ovf),
`endif
        .tx        (tx_if.master)
    );

    entry_t exp_q[$];
    int     errors    = 0;
    int     checks    = 0;
    bit     accept_en = 1'b0;
    int     busy      = 1;
    int     n_accepts = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Transmitter model and monitor: accepts a request by dropping rdy, then stays busy.
    initial begin
        entry_t e;
        tx_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (tx_if.stb && tx_if.rdy && accept_en) begin
                n_accepts++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 64'(tx_if.data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_sel", 64'(tx_if.sel), 64'(e.sel));
                    chk("accept_data", 64'(tx_if.data), 64'(e.data));
                end
                tx_if.rdy = 1'b0;
                repeat (busy) @(posedge clk);
                #2;
                tx_if.rdy = 1'b1;
            end
        end
    end

    task automatic push_entry(input logic [2:0] s, input logic [31:0] d, input bit accepted);
        entry_t e;
        push = 1'b1;
        sel  = s;
        data = d;
        e.sel  = s;
        e.data = d;
        if (accepted) exp_q.push_back(e);
        @(negedge clk);
        push = 1'b0;
        sel  = 3'd0;
        data = 32'd0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || count != 3'd0 || tx_if.rdy !== 1'b1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  a0;
        int  c0;
        bit  pop_now;
        bit  seen;
        int  sent;
        int  coinc;
        int  t;

        rst_n = 1'b0;
        push  = 1'b0;
        sel   = 3'd0;
        data  = 32'd0;
`ifdef LOGIP_TXQ_OVF_EN
        clr_ovf = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_stb", 64'(tx_if.stb), 64'd0);
`ifdef LOGIP_TXQ_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single message latency
        busy = 3;
        accept_en = 1'b1;
        push_entry(3'd2, 32'h0000_BEEF, 1'b1);
        chk("single_count_n1", 64'(count), 64'd1);
        chk("single_stb_n1", 64'(tx_if.stb), 64'd0);
        @(negedge clk);
        chk("single_stb_n2", 64'(tx_if.stb), 64'd1);
        chk("single_sel_n2", 64'(tx_if.sel), 64'd2);
        chk("single_data_n2", 64'(tx_if.data), 64'h0000_BEEF);
        @(negedge clk);
        chk("single_count_pop", 64'(count), 64'd0);
        chk("single_stb_pop", 64'(tx_if.stb), 64'd0);
        chk("single_empty_pop", 64'(empty), 64'd1);
        wait_drain("single_drain");

        // XOFF hold: stb stays up while the transmitter never drops rdy
        busy = 2;
        accept_en = 1'b0;
        push_entry(3'd3, 32'h00A1_B2C3, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            chk("xoff_stb", 64'(tx_if.stb), 64'd1);
            chk("xoff_count", 64'(count), 64'd1);
            chk("xoff_head", 64'(tx_if.data), 64'h00A1_B2C3);
            @(negedge clk);
        end
        a0 = n_accepts;
        accept_en = 1'b1;
        wait_drain("xoff_drain");
        chk("xoff_one_pop", 64'(n_accepts - a0), 64'd1);

        // Fill and overflow
        accept_en = 1'b0;
        for (int i = 0; i < 5; i++) push_entry(3'd1, 32'(17 * (i + 1)), i < 4);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_head", 64'(tx_if.data), 64'h11);
`ifdef LOGIP_TXQ_OVF_EN
        chk("ovf_set", 64'(ovf), 64'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clear", 64'(ovf), 64'd0);
`endif
        accept_en = 1'b1;
        wait_drain("fill_drain");
        chk("fill_empty_after", 64'(empty), 64'd1);
        chk("fill_full_after", 64'(full), 64'd0);

        // Zero-length push is ignored
        push_entry(3'd0, 32'h0000_DEAD, 1'b0);
        chk("zero_count", 64'(count), 64'd0);
        chk("zero_empty", 64'(empty), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (tx_if.stb) seen = 1'b1;
        end
        chk("zero_no_stb", 64'(seen), 64'd0);

        // Streaming across pointer wrap with coincident push/pop
        busy  = 1;
        sent  = 0;
        coinc = 0;
        t     = 0;
        while (sent < 10 && t < 400) begin
            if (!full) begin
                c0 = int'(count);
                pop_now = tx_if.stb && !tx_if.rdy;
                push_entry(3'(sent % 4 + 1), 32'hC0DE_0000 + 32'(sent), 1'b1);
                chk("wrap_count", 64'(count), 64'(c0 + 1 - int'(pop_now)));
                if (pop_now) coinc++;
                sent++;
            end else begin
                @(negedge clk);
            end
            t++;
        end
        chk("wrap_sent", 64'(sent), 64'd10);
        chk("wrap_coincident_seen", 64'(coinc > 0), 64'd1);
        wait_drain("wrap_drain");

        // Reset while in ISSUE with entries queued
        accept_en = 1'b0;
        for (int i = 0; i < 3; i++) push_entry(3'd4, 32'hAB00_0000 + 32'(i), 1'b0);
        @(negedge clk);
        chk("rst_pre_stb", 64'(tx_if.stb), 64'd1);
        chk("rst_pre_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_stb", 64'(tx_if.stb), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        accept_en = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_if.stb) seen = 1'b1;
        end
        chk("rst_no_stb", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
